// File: rtl/uart_tx_core_if.sv
// Byte-stream handshake and serial-line signals of the UART transmitter.
// The producer side (a bus master or a bench) uses the master modport,
// the transmitter core uses the slave modport.
interface uart_tx_core_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  tx_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output tx_o,
        output busy_o
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: a small byte FIFO feeding an 8N1 (optionally 8E1)
// serialiser. Frames are sent back to back whenever the FIFO still holds
// data at the end of a stop bit, so a burst goes out with no idle gap.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_tx_core_if.slave  bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // Reject parameter values the timing and pointer arithmetic cannot handle.
    generate
        if (CLKS_PER_BIT < 2) begin : g_badClksPerBit
            $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_badFifoDepth
            $error("uart_tx_core: FIFO_DEPTH must be a power of two and at least 2");
        end
        if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_badParityEn
            $error("uart_tx_core: PARITY_EN must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    // Serialiser state
    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;

    logic          w_ready;
    logic          w_notEmpty;
    logic          w_push;
    logic          w_pop;
    logic          w_bitEnd;
    logic [7:0]    w_head;

    // Ready depends only on occupancy, so a pop on the same edge can never
    // let a byte slip into a full buffer.
    assign w_ready    = (r_count < FULL_CNT);
    assign w_notEmpty = (r_count != '0);
    assign w_push     = bus.valid_i && w_ready;
    assign w_bitEnd   = (r_baud == BAUD_MAX);
    assign w_head     = r_mem[r_rdPtr];

    // The head is consumed either from idle or right at the end of a stop
    // bit; both decisions look at the registered count, so a byte written on
    // this edge is never visible to the serialiser until the next edge.
    assign w_pop = w_notEmpty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

    assign bus.ready_o = w_ready;
    assign bus.tx_o    = r_tx;
    assign bus.busy_o  = r_busy;

    // Buffer storage is written at the tail; its contents need no reset
    // because the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus.data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; a
    // simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer with registered line and busy outputs. The shift
    // register rotates rather than shifts, so after the eight data bits it
    // still holds every data bit and the parity bit can be taken from it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (w_bitEnd) begin
                        r_baud   <= '0;
                        r_bitIdx <= '0;
                        r_state  <= DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                DATA: begin
                    if (w_bitEnd) begin
                        r_baud <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_bitIdx <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_tx    <= ^r_shift;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {r_shift[0], r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                PARITY: begin
                    if (w_bitEnd) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                STOP: begin
                    if (w_bitEnd) begin
                        r_baud <= '0;
                        if (w_notEmpty) begin
                            r_shift <= w_head;
                            r_state <= START;
                            r_tx    <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: one instance without parity and one with even
// parity, both at 8 clocks per bit with a 4-entry buffer. The serial line
// is recorded one sample per clock and decoded by a simple UART receiver
// model; decoded bytes are compared with the bytes that were pushed.
module tb_uart_tx_core;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int LOGN  = 4096;

    typedef logic [7:0] byte_q_t[$];
    typedef int         int_q_t[$];

    typedef struct {
        logic [7:0] data;
        logic       expParity;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic txLog    [LOGN];
    logic busyLog  [LOGN];
    logic readyLog [LOGN];

    logic [7:0] decBytes  [$];
    logic       decParity [$];
    int         decStarts [$];
    int         stopErrs;
    int         parityErrs;

    uart_tx_core_if bus0 ();
    uart_tx_core_if bus1 ();

    uart_tx_core #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (0),
        .FIFO_DEPTH   (DEPTH)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    uart_tx_core #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something never terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic txOf(input bit sel);
        return sel ? bus1.tx_o : bus0.tx_o;
    endfunction

    function automatic logic busyOf(input bit sel);
        return sel ? bus1.busy_o : bus0.busy_o;
    endfunction

    function automatic logic readyOf(input bit sel);
        return sel ? bus1.ready_o : bus0.ready_o;
    endfunction

    task automatic driveIn(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            bus1.valid_i = v;
            bus1.data_i  = d;
        end else begin
            bus0.valid_i = v;
            bus0.data_i  = d;
        end
    endtask

    // Push each byte after its idle gap, holding valid until the buffer accepts
    task automatic applyStimulus(input bit sel, input byte_q_t bytes, input int_q_t gaps);
        int waitCnt;
        for (int k = 0; k < bytes.size(); k++) begin
            repeat (gaps[k]) @(negedge clk);
            @(negedge clk);
            driveIn(sel, 1'b1, bytes[k]);
            waitCnt = 0;
            while (readyOf(sel) !== 1'b1 && waitCnt < 2000) begin
                @(negedge clk);
                waitCnt++;
            end
            if (waitCnt >= 2000) begin
                checkOutput("push.timeout", 32'd0, 32'd1);
                driveIn(sel, 1'b0, 8'h00);
                return;
            end
            @(posedge clk);
            if (k == bytes.size() - 1 || gaps[k+1] != 0) begin
                #1 driveIn(sel, 1'b0, 8'h00);
            end
        end
    endtask

    // One sample of each output per clock, taken on the falling edge
    task automatic recordLine(input bit sel, input int n);
        for (int i = 0; i < n && i < LOGN; i++) begin
            @(negedge clk);
            txLog[i]    = txOf(sel);
            busyLog[i]  = busyOf(sel);
            readyLog[i] = readyOf(sel);
        end
    endtask

    // Receiver model: find a low level, sample each bit in its middle
    task automatic decodeLine(input int parityEn, input int n);
        int frameLen;
        int i;
        logic [7:0] b;
        logic pb;
        decBytes.delete();
        decParity.delete();
        decStarts.delete();
        stopErrs   = 0;
        parityErrs = 0;
        frameLen   = (10 + parityEn) * CPB;
        i = 0;
        while (i < n) begin
            if (txLog[i] == 1'b0) begin
                if (i + frameLen > n) begin
                    stopErrs++;
                    break;
                end
                for (int k = 0; k < 8; k++) begin
                    b[k] = txLog[i + CPB*(k+1) + CPB/2];
                end
                if (parityEn != 0) begin
                    pb = txLog[i + CPB*9 + CPB/2];
                    decParity.push_back(pb);
                    if (pb != ^b) parityErrs++;
                end
                if (txLog[i + CPB*(9+parityEn) + CPB/2] != 1'b1) stopErrs++;
                decBytes.push_back(b);
                decStarts.push_back(i);
                i += frameLen;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int countBusy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (busyLog[i] == 1'b1) c++;
        return c;
    endfunction

    function automatic int firstLow(input int n);
        for (int i = 0; i < n; i++) if (txLog[i] == 1'b0) return i;
        return -1;
    endfunction

    // Ideal line level for a single 8N1 frame whose start bit begins at rel = 0
    function automatic logic idealTx(input logic [7:0] d, input int rel);
        int slot;
        if (rel < 0 || rel >= 10*CPB) return 1'b1;
        slot = rel / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] decAt(input int idx);
        if (idx < decBytes.size()) return {24'd0, decBytes[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        vec_t vecs[6];
        byte_q_t q;
        int_q_t  g;
        int mm;
        int idx;
        int runLen;
        int total;
        int n;
        bit sel;
        string s;

        vecs[0] = '{8'h07, 1'b1};
        vecs[1] = '{8'h03, 1'b0};
        vecs[2] = '{8'hA5, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'h3C, 1'b0};
        vecs[5] = '{8'hFE, 1'b1};

        driveIn(1'b0, 1'b0, 8'h00);
        driveIn(1'b1, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.tx0",    bus0.tx_o,    1);
        checkOutput("reset.busy0",  bus0.busy_o,  0);
        checkOutput("reset.ready0", bus0.ready_o, 1);
        checkOutput("reset.tx1",    bus1.tx_o,    1);
        checkOutput("reset.busy1",  bus1.busy_o,  0);
        checkOutput("reset.ready1", bus1.ready_o, 1);
        rst = 1'b0;

        // Single byte into an idle transmitter: exact waveform and busy length
        q = '{8'h55};
        g = '{0};
        fork
            recordLine(1'b0, 100);
            applyStimulus(1'b0, q, g);
        join
        decodeLine(0, 100);
        mm = 0;
        for (int i = 0; i < 100; i++) if (txLog[i] !== idealTx(8'h55, i - 2)) mm++;
        checkOutput("single.firstLow", firstLow(100), 2);
        checkOutput("single.waveErrs", mm, 0);
        checkOutput("single.busyCycles", countBusy(100), 80);
        checkOutput("single.busyStart", {busyLog[1], busyLog[2]}, 2'b01);
        checkOutput("single.byte", decAt(0), 32'h55);

        // Three bytes back to back: contiguous frames
        q = '{8'h41, 8'h42, 8'h0A};
        g = '{0, 0, 0};
        fork
            recordLine(1'b0, 260);
            applyStimulus(1'b0, q, g);
        join
        decodeLine(0, 260);
        checkOutput("b2b.count", decBytes.size(), 3);
        for (int k = 0; k < 3; k++) checkOutput($sformatf("b2b.byte%0d", k), decAt(k), {24'd0, q[k]});
        checkOutput("b2b.busyCycles", countBusy(260), 240);
        if (decStarts.size() == 3) begin
            checkOutput("b2b.gap01", decStarts[1] - decStarts[0], 80);
            checkOutput("b2b.gap12", decStarts[2] - decStarts[1], 80);
        end else begin
            checkOutput("b2b.starts", decStarts.size(), 3);
        end
        s = "";
        foreach (decBytes[k]) if (decBytes[k] != 8'h0A) s = $sformatf("%s%c", s, decBytes[k]);
        $display("[TB] [UART]: %s", s);

        // Six bytes with valid held: buffer fills, stalled byte taken later
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        g = '{0, 0, 0, 0, 0, 0};
        fork
            recordLine(1'b0, 520);
            applyStimulus(1'b0, q, g);
        join
        decodeLine(0, 520);
        idx = -1;
        for (int i = 0; i < 520; i++) if (readyLog[i] == 1'b0) begin idx = i; break; end
        runLen = 0;
        if (idx >= 0) for (int i = idx; i < 520 && readyLog[i] == 1'b0; i++) runLen++;
        checkOutput("full.readyLowAt", idx, 5);
        checkOutput("full.readyLowRun", runLen, 77);
        checkOutput("full.count", decBytes.size(), 6);
        for (int k = 0; k < 6; k++) checkOutput($sformatf("full.byte%0d", k), decAt(k), {24'd0, q[k]});
        checkOutput("full.busyCycles", countBusy(520), 480);
        checkOutput("full.stopErrs", stopErrs, 0);

        // Table of single frames sent through both instances
        for (int v = 0; v < 6; v++) begin
            for (int si = 0; si < 2; si++) begin
                sel = si[0];
                q = '{vecs[v].data};
                g = '{0};
                n = (10 + si) * CPB + 20;
                fork
                    recordLine(sel, n);
                    applyStimulus(sel, q, g);
                join
                decodeLine(si, n);
                checkOutput($sformatf("vec%0d.p%0d.byte", v, si), decAt(0), {24'd0, vecs[v].data});
                checkOutput($sformatf("vec%0d.p%0d.busy", v, si), countBusy(n), (10 + si) * CPB);
                checkOutput($sformatf("vec%0d.p%0d.stop", v, si), stopErrs, 0);
                if (si == 1) begin
                    checkOutput($sformatf("vec%0d.parity", v),
                                decParity.size() > 0 ? {31'd0, decParity[0]} : 32'hFFFF_FFFF,
                                {31'd0, vecs[v].expParity});
                end
            end
        end

        // Reset during data bit 3 of 0xF0 with two more bytes queued
        q = '{8'hF0, 8'hA1, 8'hB2};
        g = '{0, 0, 0};
        fork
            recordLine(1'b0, 37);
            applyStimulus(1'b0, q, g);
        join
        checkOutput("rst.preTx", txLog[36], 0);
        checkOutput("rst.preBusy", busyLog[36], 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst.tx", bus0.tx_o, 1);
        checkOutput("rst.busy", bus0.busy_o, 0);
        checkOutput("rst.ready", bus0.ready_o, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        recordLine(1'b0, 200);
        mm = 0;
        for (int i = 0; i < 200; i++) if (txLog[i] !== 1'b1) mm++;
        checkOutput("rst.postLowSamples", mm, 0);
        checkOutput("rst.postBusy", countBusy(200), 0);

        // A byte offered during release is taken on the very first edge
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        driveIn(1'b0, 1'b1, 8'h3C);
        fork
            recordLine(1'b0, 100);
            begin
                @(posedge clk);
                #1 driveIn(1'b0, 1'b0, 8'h00);
            end
        join
        decodeLine(0, 100);
        checkOutput("release.firstLow", firstLow(100), 1);
        checkOutput("release.count", decBytes.size(), 1);
        checkOutput("release.byte", decAt(0), 32'h3C);

        // Push on the same edge the sequencer pops, with two bytes buffered
        q = '{8'hC1, 8'hC2, 8'hC3};
        g = '{0, 0, 0};
        fork
            recordLine(1'b0, 360);
            begin
                applyStimulus(1'b0, q, g);
                repeat (78) @(negedge clk);
                applyStimulus(1'b0, '{8'hC4}, '{0});
                @(negedge clk);
                checkOutput("pushpop.occupancy", {29'd0, dut0.r_count}, 2);
            end
        join
        decodeLine(0, 360);
        checkOutput("pushpop.count", decBytes.size(), 4);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("pushpop.byte%0d", k), decAt(k), 32'hC1 + k);
        checkOutput("pushpop.busyCycles", countBusy(360), 320);

        // Random bursts with random gaps against the scoreboard of pushed bytes
        for (int it = 0; it < 4; it++) begin
            sel = it[0];
            n = $urandom_range(4, 7);
            q.delete();
            g.delete();
            total = 0;
            for (int k = 0; k < n; k++) begin
                q.push_back(8'($urandom));
                g.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(60, 120) : $urandom_range(0, 4));
                total += g[k];
            end
            total += (n + 1) * (10 + it % 2) * CPB + 40;
            fork
                recordLine(sel, total);
                applyStimulus(sel, q, g);
            join
            decodeLine(it % 2, total);
            checkOutput($sformatf("rand%0d.count", it), decBytes.size(), n);
            for (int k = 0; k < n; k++) checkOutput($sformatf("rand%0d.byte%0d", it, k), decAt(k), {24'd0, q[k]});
            checkOutput($sformatf("rand%0d.stop", it), stopErrs, 0);
            checkOutput($sformatf("rand%0d.parity", it), parityErrs, 0);
            checkOutput($sformatf("rand%0d.busy", it), countBusy(total), n * (10 + it % 2) * CPB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
